// File: rtl/ds_correlator.sv
// Multi-channel delta-sigma window counter and correlator.
// Counts high samples per window, correlates against ch0, accumulates per measurement.
module ds_correlator #(
  parameter int NUM_CH          = 2,
  parameter int WINDOW          = 128,
  parameter int DISCARD_WINDOWS = 1,
  parameter int ACCUM_WINDOWS   = 1200,
  parameter int ACC_W           = 32,
  parameter int OUT_SHIFT       = 16
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [NUM_CH-1:0]                        ds_in,
  input  logic                                     start,
  output logic                                     busy,
  output logic                                     win_strobe,
  output logic [NUM_CH*$clog2(WINDOW+1)-1:0]       win_count,
  output logic                                     res_valid,
  input  logic                                     res_ready,
  output logic [(NUM_CH-1)*ACC_W-1:0]              res_data,
  output logic [(NUM_CH-1)*16-1:0]                 res_scaled,
  output logic                                     overrun
);

  localparam int CNT_W  = $clog2(WINDOW+1);
  localparam int SMP_W  = $clog2(WINDOW);
  localparam int PW     = 2*CNT_W;
  localparam int NWIN   = DISCARD_WINDOWS + ACCUM_WINDOWS;
  localparam int WI_W   = $clog2(NWIN+1);
  localparam int SUM_W  = ((ACC_W > PW) ? ACC_W : PW) + 1;
  localparam int SET_LAST = (DISCARD_WINDOWS > 0) ? DISCARD_WINDOWS-1 : 0;
  localparam int ACC_LAST = NWIN-1;
  localparam int NR     = NUM_CH-1;

  typedef enum logic [1:0] {IDLE, SETTLE, ACCUM, DRAIN} state_t;

  state_t           state;
  logic [SMP_W-1:0] samp;
  logic [WI_W-1:0]  widx;
  logic [CNT_W-1:0] cnt [NUM_CH];
  logic [PW-1:0]    prod [NR];
  logic [ACC_W-1:0] acc [NR];
  logic [ACC_W-1:0] acc_next [NR];
  logic             cl, cl_acc, cl_last;
  logic             pv, plast;
  logic             counting, close;

  assign counting = (state == SETTLE) || (state == ACCUM);
  assign close    = counting && (samp == SMP_W'(WINDOW-1));

  // saturating accumulate of the pending product
  always_comb begin
    for (int c = 0; c < NR; c++) begin
      logic [SUM_W-1:0] sum;
      sum = SUM_W'(acc[c]) + SUM_W'(prod[c]);
      acc_next[c] = acc[c];
      if (pv) begin
        if (sum > SUM_W'({ACC_W{1'b1}}))
          acc_next[c] = {ACC_W{1'b1}};
        else
          acc_next[c] = sum[ACC_W-1:0];
      end
    end
  end

  // sequencer, window counters, product pipeline and result handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      samp       <= '0;
      widx       <= '0;
      busy       <= 1'b0;
      win_strobe <= 1'b0;
      win_count  <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      overrun    <= 1'b0;
      cl         <= 1'b0;
      cl_acc     <= 1'b0;
      cl_last    <= 1'b0;
      pv         <= 1'b0;
      plast      <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) cnt[c] <= '0;
      for (int c = 0; c < NR; c++) begin
        prod[c] <= '0;
        acc[c]  <= '0;
      end
    end else begin
      win_strobe <= close;
      cl         <= close;
      cl_acc     <= close && (state == ACCUM);
      cl_last    <= close && (state == ACCUM) &&
                    (int'(widx) == ACC_LAST);
      pv         <= cl && cl_acc;
      plast      <= cl && cl_last;

      if (cl) begin
        for (int c = 1; c < NUM_CH; c++)
          prod[c-1] <= PW'(win_count[c*CNT_W +: CNT_W]) *
                       PW'(win_count[0 +: CNT_W]);
      end

      if (state == IDLE) begin
        if (start) begin
          state <= (DISCARD_WINDOWS > 0) ? SETTLE : ACCUM;
          busy  <= 1'b1;
          samp  <= '0;
          widx  <= '0;
          for (int c = 0; c < NUM_CH; c++) cnt[c] <= '0;
        end
      end else if (counting) begin
        if (close) begin
          samp <= '0;
          widx <= widx + 1'b1;
          for (int c = 0; c < NUM_CH; c++) begin
            win_count[c*CNT_W +: CNT_W] <= cnt[c] + CNT_W'(ds_in[c]);
            cnt[c] <= '0;
          end
          if (state == SETTLE && int'(widx) == SET_LAST)
            state <= ACCUM;
          else if (state == ACCUM && int'(widx) == ACC_LAST)
            state <= DRAIN;
        end else begin
          samp <= samp + 1'b1;
          for (int c = 0; c < NUM_CH; c++)
            cnt[c] <= cnt[c] + CNT_W'(ds_in[c]);
        end
      end

      if (plast) begin
        for (int c = 0; c < NR; c++) begin
          res_data[c*ACC_W +: ACC_W] <= acc_next[c];
          acc[c] <= '0;
        end
        res_valid <= 1'b1;
        if (res_valid && !res_ready) overrun <= 1'b1;
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        for (int c = 0; c < NR; c++) acc[c] <= acc_next[c];
        if (res_valid && res_ready) res_valid <= 1'b0;
      end
    end
  end

  // scaled view of each result, clamped to 16 bits
  for (genvar g = 0; g < NR; g++) begin : g_scale
    logic [ACC_W+15:0] shw;
    assign shw = {16'b0, res_data[g*ACC_W +: ACC_W]} >> OUT_SHIFT;
    assign res_scaled[g*16 +: 16] =
      (shw > (ACC_W+16)'(16'hFFFF)) ? 16'hFFFF : shw[15:0];
  end

endmodule

// File: tb/tb_ds_correlator.sv
// Directed bench for ds_correlator.
// NUM_CH=2, WINDOW=8, DISCARD=1, ACCUM=4; second instance with ACC_W=8.
module tb_ds_correlator;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  ds_in;
  logic        start;
  logic        res_ready;
  logic        busy, win_strobe, res_valid, overrun;
  logic [7:0]  win_count;
  logic [31:0] res_data;
  logic [15:0] res_scaled;
  logic        busy8, ws8, rv8, ov8;
  logic [7:0]  wc8;
  logic [7:0]  rd8;
  logic [15:0] rs8;

  int errors = 0;
  int checks = 0;
  logic alt = 1'b0;

  always #5 clk = ~clk;

  ds_correlator #(.NUM_CH(2), .WINDOW(8), .DISCARD_WINDOWS(1),
    .ACCUM_WINDOWS(4), .ACC_W(32), .OUT_SHIFT(16)) u_dut (
    .clk(clk), .rst(rst), .ds_in(ds_in), .start(start),
    .busy(busy), .win_strobe(win_strobe), .win_count(win_count),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_scaled(res_scaled), .overrun(overrun));

  ds_correlator #(.NUM_CH(2), .WINDOW(8), .DISCARD_WINDOWS(1),
    .ACCUM_WINDOWS(4), .ACC_W(8), .OUT_SHIFT(16)) u_sat (
    .clk(clk), .rst(rst), .ds_in(ds_in), .start(start),
    .busy(busy8), .win_strobe(ws8), .win_count(wc8),
    .res_valid(rv8), .res_ready(res_ready),
    .res_data(rd8), .res_scaled(rs8), .overrun(ov8));

  task automatic tick();
    @(posedge clk);
    #1;
    if (alt) ds_in[1] = ~ds_in[1];
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // start sampled at the edge returned from here (cycle 0)
  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ds_in = 2'b00; start = 1'b0; res_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(res_valid), 64'd0);
    chk("rst_data", 64'(res_data), 64'd0);
    chk("rst_wc", 64'(win_count), 64'd0);

    // all ones on both channels
    ds_in = 2'b11;
    do_start();
    chk("t1_busy", 64'(busy), 64'd1);
    repeat (7) tick();
    chk("t1_nostrobe7", 64'(win_strobe), 64'd0);
    tick();
    chk("t1_strobe8", 64'(win_strobe), 64'd1);
    chk("t1_wc8", 64'(win_count), 64'h88);
    tick();
    chk("t1_strobe_drop", 64'(win_strobe), 64'd0);
    repeat (7) tick();
    chk("t1_strobe16", 64'(win_strobe), 64'd1);
    chk("t1_wc16", 64'(win_count), 64'h88);
    repeat (25) tick();
    chk("t1_pre_valid", 64'(res_valid), 64'd0);
    chk("t1_pre_busy", 64'(busy), 64'd1);
    tick();
    chk("t1_valid42", 64'(res_valid), 64'd1);
    chk("t1_data", 64'(res_data), 64'd256);
    chk("t1_busy42", 64'(busy), 64'd0);
    chk("t1_scaled", 64'(res_scaled), 64'd0);
    chk("sat_data", 64'(rd8), 64'd255);
    tick();
    chk("t1_accepted", 64'(res_valid), 64'd0);

    // ch1 alternating, ch0 all ones
    ds_in = 2'b01; alt = 1'b1;
    do_start();
    repeat (8) tick();
    chk("t2_wc", 64'(win_count), 64'h48);
    repeat (34) tick();
    chk("t2_valid", 64'(res_valid), 64'd1);
    chk("t2_data", 64'(res_data), 64'd128);
    chk("t2_scaled", 64'(res_scaled), 64'd0);
    chk("t2_sat_inst", 64'(rd8), 64'd128);
    alt = 1'b0;
    tick();

    // start pulses during a measurement are ignored
    ds_in = 2'b11;
    do_start();
    repeat (4) tick();
    do_start();
    repeat (14) tick();
    do_start();
    chk("t4_busy", 64'(busy), 64'd1);
    repeat (21) tick();
    chk("t4_pre_valid", 64'(res_valid), 64'd0);
    // start arrives on the completion edge and must be ignored
    do_start();
    chk("t4_valid42", 64'(res_valid), 64'd1);
    chk("t4_data", 64'(res_data), 64'd256);
    chk("t4_busy_after", 64'(busy), 64'd0);
    repeat (10) tick();
    chk("t4_no_restart", 64'(busy), 64'd0);

    // overrun: consumer stalls across two results
    res_ready = 1'b0;
    do_start();
    repeat (42) tick();
    chk("t3_first", 64'(res_data), 64'd256);
    chk("t3_ov0", 64'(overrun), 64'd0);
    ds_in = 2'b01; alt = 1'b1;
    do_start();
    repeat (42) tick();
    chk("t3_hold_valid", 64'(res_valid), 64'd1);
    chk("t3_overwrite", 64'(res_data), 64'd128);
    chk("t3_ov1", 64'(overrun), 64'd1);
    alt = 1'b0; ds_in = 2'b11;
    res_ready = 1'b1;
    tick();
    chk("t3_drop", 64'(res_valid), 64'd0);
    chk("t3_sticky", 64'(overrun), 64'd1);

    // reset in the middle of a measurement
    do_start();
    repeat (19) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_ov", 64'(overrun), 64'd0);
    chk("t5_wc", 64'(win_count), 64'd0);
    chk("t5_valid", 64'(res_valid), 64'd0);
    chk("t5_data", 64'(res_data), 64'd0);
    chk("t5_strobe", 64'(win_strobe), 64'd0);
    tick();
    do_start();
    repeat (41) tick();
    chk("t5_pre_valid", 64'(res_valid), 64'd0);
    tick();
    chk("t5_valid", 64'(res_valid), 64'd1);
    chk("t5_result", 64'(res_data), 64'd256);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
